// File: rtl/pipelined_addsub.sv
`timescale 1ns/1ps
// pipelined_addsub: WIDTH-bit adder/subtractor with the carry chain cut into SEG-bit segments, one per stage.
// Latency: STAGES = WIDTH/SEG cycles from input transfer to out_valid, plus any cycles spent stalled.
// Backpressure: a single advance enable (!out_valid || out_ready) freezes every stage, bubbles included.
module pipelined_addsub #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  localparam int STAGES = WIDTH / SEG;
  localparam int LAST   = STAGES - 1;
  localparam int MSB    = WIDTH - 1;

  // Reject geometries that cannot be split into whole segments.
  generate
    if (WIDTH < 2) begin : g_bad_width
      $error("pipelined_addsub: WIDTH must be at least 2");
    end
    if ((SEG < 1) || (SEG > WIDTH) || ((WIDTH % SEG) != 0)) begin : g_bad_seg
      $error("pipelined_addsub: SEG must divide WIDTH exactly");
    end
  endgenerate

  // Stage inputs: what each stage sees this cycle (stage 0 from the ports,
  // later stages from the register bank of the stage before).
  logic             w_adv;
  logic [WIDTH-1:0] w_a_in  [STAGES];
  logic [WIDTH-1:0] w_b_in  [STAGES];
  logic [WIDTH-1:0] w_s_in  [STAGES];
  logic             w_c_in  [STAGES];
  logic             w_v_in  [STAGES];
  logic [SEG:0]     w_seg   [STAGES];
  logic [WIDTH-1:0] w_s_nxt [STAGES];
  logic             w_ovf_nxt;
  logic             w_zero_nxt;

  // Per-stage state. r_a/r_b are the operand skew registers, r_s holds the
  // partial sums resolved so far (upper segments stay zero until reached).
  logic             r_vld [STAGES];
  logic             r_cy  [STAGES];
  logic [WIDTH-1:0] r_a   [STAGES];
  logic [WIDTH-1:0] r_b   [STAGES];
  logic [WIDTH-1:0] r_s   [STAGES];
  logic             r_ovf;
  logic             r_zero;

  // Everything moves together, so a full pipe can still accept while it drains.
  assign w_adv    = !r_vld[LAST] || out_ready;
  assign in_ready = w_adv;

  genvar k;
  generate
    for (k = 0; k < STAGES; k++) begin : g_stage
      if (k == 0) begin : g_first
        // Subtraction inverts B once at capture; the caller supplies cin=1 for a true A-B.
        assign w_a_in[k] = a;
        assign w_b_in[k] = sub ? ~b : b;
        assign w_c_in[k] = cin;
        assign w_s_in[k] = '0;
        assign w_v_in[k] = in_valid;
      end else begin : g_next
        assign w_a_in[k] = r_a[k-1];
        assign w_b_in[k] = r_b[k-1];
        assign w_c_in[k] = r_cy[k-1];
        assign w_s_in[k] = r_s[k-1];
        assign w_v_in[k] = r_vld[k-1];
      end

      // One SEG-bit slice of the carry chain; bit SEG is the carry into the next stage.
      assign w_seg[k] = {1'b0, w_a_in[k][k*SEG +: SEG]}
                      + {1'b0, w_b_in[k][k*SEG +: SEG]}
                      + {{SEG{1'b0}}, w_c_in[k]};

      // Merge this slice into the accumulated lower partial sums.
      assign w_s_nxt[k] = w_s_in[k] | (WIDTH'(w_seg[k][SEG-1:0]) << (k * SEG));
    end
  endgenerate

  // Flags need the complete sum, so they are formed where the last slice resolves.
  assign w_ovf_nxt  = (w_a_in[LAST][MSB] == w_b_in[LAST][MSB]) &&
                      (w_s_nxt[LAST][MSB] != w_a_in[LAST][MSB]);
  assign w_zero_nxt = ~|w_s_nxt[LAST];

  // Shift all stages in lock-step on advance; reset flushes every in-flight operation.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= 1'b0;
        r_cy[i]  <= 1'b0;
        r_a[i]   <= '0;
        r_b[i]   <= '0;
        r_s[i]   <= '0;
      end
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (w_adv) begin
      for (int i = 0; i < STAGES; i++) begin
        r_vld[i] <= w_v_in[i];
        r_cy[i]  <= w_seg[i][SEG];
        r_a[i]   <= w_a_in[i];
        r_b[i]   <= w_b_in[i];
        r_s[i]   <= w_s_nxt[i];
      end
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign out_valid = r_vld[LAST];
  assign sum       = r_s[LAST];
  assign cout      = r_cy[LAST];
  assign ovf       = r_ovf;
  assign zero      = r_zero;

endmodule

// File: tb/tb_pipelined_addsub.sv
`timescale 1ns/1ps
// tb_pipelined_addsub: directed vectors for the 16-bit / 4-bit-segment configuration.
// Latency: results expected four cycles after presentation when not stalled.
// Backpressure: out_ready is dropped for three cycles mid-stream to exercise the stall path.
module tb_pipelined_addsub;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        zero;

  always #5 clk = ~clk;

  pipelined_addsub #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .zero      (zero)
  );

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
    logic        z;
  } exp_t;

  exp_t        exp_q [$];
  int          n_cmp = 0;
  int          n_bad = 0;
  logic        prev_stall = 1'b0;
  logic [15:0] prev_sum = 16'h0000;
  logic        seen;
  logic        found;

  logic [15:0] bp_a [6] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6};
  logic [15:0] bp_s [6] = '{16'd2, 16'd4, 16'd6, 16'd8, 16'd10, 16'd12};

  task automatic chk1(input string name, input logic act, input logic req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %b, want %b (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic chk16(input string name, input logic [15:0] act, input logic [15:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%04h, want 0x%04h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Present one operation, hold it until accepted, and queue its expected result.
  task automatic send(input logic [15:0] ta, input logic [15:0] tb_v, input logic tc,
                      input logic ts, input logic [15:0] es, input logic ec,
                      input logic eo, input logic ez);
    logic rdy;
    logic done;
    exp_t e;
    a        = ta;
    b        = tb_v;
    cin      = tc;
    sub      = ts;
    in_valid = 1'b1;
    done     = 1'b0;
    for (int w = 0; w < 40 && !done; w++) begin
      @(negedge clk);
      rdy = in_ready;
      @(posedge clk);
      if (rdy) begin
        e.s = es;
        e.c = ec;
        e.o = eo;
        e.z = ez;
        exp_q.push_back(e);
        done = 1'b1;
      end
    end
    #1;
    in_valid = 1'b0;
    chk1("send_accepted", done, 1'b1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Monitor: pop and compare on every output transfer; also watch stalled outputs stay put.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          chk1("stall_hold_valid", out_valid, 1'b1);
          chk16("stall_hold_sum", sum, prev_sum);
        end
        if (out_valid && out_ready) begin
          chk1("result_expected", exp_q.size() != 0, 1'b1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk16("sum", sum, e.s);
            chk1("cout", cout, e.c);
            chk1("ovf", ovf, e.o);
            chk1("zero", zero, e.z);
          end
        end
        prev_stall = out_valid && !out_ready;
        prev_sum   = sum;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    a         = 16'h0000;
    b         = 16'h0000;
    cin       = 1'b0;
    sub       = 1'b0;
    out_ready = 1'b0;

    // Reset state; out_ready is low so in_ready can only be high because the pipe is empty.
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk1("rst_out_valid", out_valid, 1'b0);
    chk16("rst_sum", sum, 16'h0000);
    chk1("rst_cout", cout, 1'b0);
    chk1("rst_ovf", ovf, 1'b0);
    chk1("rst_zero", zero, 1'b0);
    chk1("rst_in_ready", in_ready, 1'b1);
    rst       = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;

    // Basic add with exact latency.
    send(16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk1("latency_out_valid", out_valid, (i == 3));
    end
    idle(2);

    // Carry through every segment, subtraction, signed overflow, cin=0 subtract.
    send(16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    send(16'h7FFF, 16'hFFFF, 1'b1, 1'b1, 16'h8000, 1'b0, 1'b1, 1'b0);
    send(16'h1234, 16'h1234, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1);
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1);
    send(16'h0010, 16'h0001, 1'b0, 1'b1, 16'h000E, 1'b1, 1'b0, 1'b0);
    idle(8);

    // Back-to-back stream with a three-cycle output stall.
    fork
      begin
        for (int i = 0; i < 6; i++)
          send(bp_a[i], bp_a[i], 1'b0, 1'b0, bp_s[i], 1'b0, 1'b0, 1'b0);
      end
      begin
        seen = 1'b0;
        for (int w = 0; w < 20 && !seen; w++) begin
          @(posedge clk);
          #1;
          seen = out_valid;
        end
        chk1("bp_first_result", seen, 1'b1);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
          @(negedge clk);
          chk1("bp_in_ready_low", in_ready, 1'b0);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    idle(10);
    chk1("bp_all_drained", exp_q.size() == 0, 1'b1);

    // Bubbles between operations appear unchanged at the output.
    fork
      begin
        send(16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(16'hABCD, 16'h1111, 1'b0, 1'b0, 16'hBCDE, 1'b0, 1'b0, 1'b0);
        idle(1);
        send(16'h4000, 16'h4000, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
      end
      begin
        found = 1'b0;
        for (int w = 0; w < 20 && !found; w++) begin
          @(negedge clk);
          found = out_valid;
        end
        chk1("bub_first_result", found, 1'b1);
        for (int i = 1; i < 7; i++) begin
          @(negedge clk);
          chk1("bub_pattern", out_valid, (i % 2 == 0));
        end
      end
    join
    idle(8);

    // Reset while three operations are in flight: none may emerge.
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    send(16'h0003, 16'h0004, 1'b0, 1'b0, 16'h0007, 1'b0, 1'b0, 1'b0);
    send(16'h0005, 16'h0006, 1'b0, 1'b0, 16'h000B, 1'b0, 1'b0, 1'b0);
    rst       = 1'b1;
    out_ready = 1'b0;
    @(posedge clk);
    exp_q.delete();
    @(negedge clk);
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk16("midrst_sum", sum, 16'h0000);
    chk1("midrst_cout", cout, 1'b0);
    chk1("midrst_ovf", ovf, 1'b0);
    chk1("midrst_zero", zero, 1'b0);
    chk1("midrst_in_ready", in_ready, 1'b1);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk1("midrst_no_stale", out_valid, 1'b0);
    end
    @(posedge clk);
    #1;

    // Pipe still works after the flush.
    send(16'h0001, 16'h0002, 1'b0, 1'b0, 16'h0003, 1'b0, 1'b0, 1'b0);
    found = 1'b0;
    for (int w = 0; w < 20 && !found; w++) begin
      @(negedge clk);
      found = (exp_q.size() == 0);
    end
    chk1("final_drain", found, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/pipelined_addsub.md
Name: pipelined_addsub

Overview:
- Parametrised, pipelined carry-chain adder/subtractor.
- Generalises the 8-bit ripple-carry adder to any WIDTH.
- Breaks the carry chain into SEG-bit segments, with one segment per pipeline stage.
- Adds a subtract mode, signed overflow and zero flags, and a valid/ready handshake with full-pipeline backpressure. Sits in front of ALU/accumulator datapaths that need high Fmax.

Parameters:
- WIDTH, 16, operand and result width in bits; must be ≥ 2.
- SEG, 4, bits resolved per pipeline stage. WIDTH mod SEG must be 0; otherwise elaboration fails via a generate-time error.
- STAGES, WIDTH/SEG, derived local parameter. Sets the pipeline depth and the latency in cycles.

Ports:
- clk, input, 1, rising-edge clock.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operands are presented.
- in_ready, output, 1, block accepts operands this cycle.
- a, input, WIDTH, operand A.
- b, input, WIDTH, operand B.
- cin, input, 1, carry-in; set to 1 with sub=1 for a true A−B.
- sub, input, 1, 0: A+B+cin; 1: A+~B+cin.
- out_valid, output, 1, result valid.
- out_ready, input, 1, downstream accepts the result.
- sum, output, WIDTH, result.
- cout, output, 1, carry out of the MSB (raw carry; for subtraction 1 means no borrow).
- ovf, output, 1, two's-complement signed overflow.
- zero, output, 1, sum == 0.

Behaviour:
- Reset: when rst=1 at a clock edge, all stage valid bits, sum, cout, ovf and zero clear to 0.
  - out_valid=0 from the next cycle.
  - in_ready=1 after reset because the pipe is empty.
  - Reset mid-operation discards all in-flight operations; none emerge.
- Handshake:
  - Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
  - Global advance enable is adv = !out_valid || out_ready. in_ready = adv, which is combinational.
  - When adv=0, every stage register holds, including bubbles.
  - When adv=1, all stages shift by one. Stage 0 loads in_valid; if in_valid=0, a bubble enters.
  - Result data is only meaningful while out_valid=1. It must remain stable while out_valid && !out_ready.
- Datapath:
  - b_eff = sub ? ~b : b. This is applied at stage 0 capture.
  - Stage k (k = 0..STAGES−1) adds segment bits [k*SEG +: SEG] of a and b_eff plus the carry from stage k−1. Stage 0 uses cin as its carry.
  - Stage k registers its SEG-bit partial sum and its carry.
  - Unconsumed higher segments of a and b_eff travel forward in skew registers.
  - Completed lower partial sums are delayed so that all segments align at the last stage.
  - Each stage carries its valid bit and data together.
- Latency: exactly STAGES cycles from input transfer to out_valid with no backpressure; any stall cycles add to this. Throughput is 1 op/cycle while out_ready=1.
- Flags, computed at the final stage and registered with sum:
  - cout = carry out of bit WIDTH−1.
  - ovf = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]). This needs a[MSB] and b_eff[MSB] carried to the final stage.
  - zero = ~|sum.
- Wrap-around: the sum is modulo 2^WIDTH; overflow is reported only via cout and ovf.
- Simultaneous input and output transfer on a full pipe is legal, with no lost or duplicated results.
- SEG == WIDTH gives a single-stage registered adder with latency 1.
- Order is strictly FIFO.

Test Plan (WIDTH=16, SEG=4, latency 4):
- Basic add:
  - Stimulus: a=0x1234, b=0x4321, cin=0, sub=0, out_ready=1.
  - Response: exactly 4 cycles later out_valid=1, sum=0x5555, cout=0, ovf=0, zero=0.
- Full carry ripple across all segments:
  - Stimulus: a=0xFFFF, b=0x0000, cin=1.
  - Response: sum=0x0000, cout=1, zero=1, ovf=0.
- Subtract and signed overflow:
  - Stimulus 1: a=0x0005, b=0x0007, sub=1, cin=1.
  - Response 1: sum=0xFFFE, cout=0, ovf=0.
  - Stimulus 2: a=0x7FFF, b=0xFFFF, sub=1, cin=1.
  - Response 2: sum=0x8000, ovf=1.
- Back-to-back with backpressure:
  - Stimulus: stream 6 ops with values 1+1 through 6+6 on consecutive cycles. Hold out_ready=0 for 3 cycles after the first result appears.
  - Response: in_ready drops while stalled, sum is held stable, and results 2,4,6,8,10,12 appear in order with no loss or duplication.
- Bubbles:
  - Stimulus: alternate in_valid 1/0 for 4 ops.
  - Response: out_valid pattern 1,0,1,0... appears 4 cycles later with correct sums.
- Reset mid-flight:
  - Stimulus: issue 3 ops, then assert rst for 1 cycle after the 2nd cycle.
  - Response: out_valid=0 and all outputs 0 the cycle after reset, no stale results emerge, and in_ready=1.
